// File: rtl/dcs_pkg.sv
// rtl/dcs_pkg.sv - shared constants, read-FSM states and msb priority encoder
// Purpose : common definitions for the DCS output requantizer and the core.
// Ports   : none (package).
package dcs_pkg;

    localparam int N_WORDS = 8;   // words per burst, power of 2
    localparam int IN_W    = 32;  // input word width
    localparam int OUT_W   = 8;   // output byte width
    localparam int SHIFT_W = 5;   // width of the shared shift amount
    localparam int IDX_W   = $clog2(N_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DRAIN
    } rd_state_t;

    // Index of the highest set bit; 0 for a zero input.
    function automatic logic [SHIFT_W-1:0] msb_index(input logic [IN_W-1:0] v);
        logic [SHIFT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (v[i]) begin
                idx = SHIFT_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dcs_round_sat.sv
// rtl/dcs_round_sat.sv - combinational round-half-up right shift with saturation
// Purpose : q = (word + half) >> shift at IN_W+1 bits, clamped to 2^OUT_W-1.
// Ports   : word_i  - unsigned input word
//           shift_i - right-shift amount
//           byte_o  - rounded, saturated result
module dcs_round_sat
    import dcs_pkg::*;
(
    input  logic [IN_W-1:0]    word_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [OUT_W-1:0]   byte_o
);

    logic [IN_W:0] half;
    logic [IN_W:0] sum;
    logic [IN_W:0] q;

    // The extra top bit keeps the rounding carry of an all-ones word.
    always_comb begin
        half = '0;
        if (shift_i != '0) begin
            half = (IN_W+1)'(1) << (shift_i - SHIFT_W'(1));
        end
        sum    = {1'b0, word_i} + half;
        q      = sum >> shift_i;
        byte_o = (|q[IN_W:OUT_W]) ? '1 : q[OUT_W-1:0];
    end

endmodule

// File: rtl/dcs_out_requant.sv
// rtl/dcs_out_requant.sv - double-buffered burst collector and 8-bit requantizer
// Purpose : collects N_WORDS-word bursts from the core, finds each burst
//           maximum and emits the burst as rounded/saturated bytes sharing
//           one right shift.
// Ports   : clk, rst_n         - clock, async active-low reset
//           in_valid, in_data  - core result words (no backpressure)
//           out_valid/ready    - output byte handshake
//           out_data           - requantized byte
//           out_shift          - shift applied to the current burst
//           out_last           - last byte of a burst
//           overflow           - sticky, a burst was dropped
module dcs_out_requant
    import dcs_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_last,
    output logic               overflow
);

    // ------------------------------------------------------------------
    // Storage and write side
    // ------------------------------------------------------------------
    logic [IN_W-1:0]  bank_q [2][N_WORDS];
    logic [IN_W-1:0]  max_q  [2];
    logic [1:0]       full_q;
    logic [1:0]       full_d;
    logic             wr_sel_q;
    logic [IDX_W-1:0] wcnt_q;
    logic             drop_q;
    logic             overflow_q;

    logic             wr_last;
    logic             wr_bank_busy;
    logic             drop_start;
    logic             dropping;
    logic             wr_en;

    // Read side state, declared here because the write side looks at rd_free.
    rd_state_t        state_q;
    logic             rd_sel_q;
    logic [IDX_W-1:0] idx_q;
    logic [SHIFT_W-1:0] shift_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_last_q;

    logic             hs;
    logic             idx_last;
    logic             rd_free;
    logic [IDX_W-1:0] idx_nxt;
    logic [SHIFT_W-1:0] msb;
    logic [SHIFT_W-1:0] calc_shift;
    logic [IN_W-1:0]  rs_word;
    logic [SHIFT_W-1:0] rs_shift;
    logic [OUT_W-1:0] rs_byte;

    assign wr_last = (wcnt_q == IDX_W'(N_WORDS - 1));

    // A bank being released on this edge counts as free for a new burst.
    assign wr_bank_busy = full_q[wr_sel_q] & ~(rd_free & (rd_sel_q == wr_sel_q));
    assign drop_start   = in_valid & (wcnt_q == '0) & wr_bank_busy;
    assign dropping     = drop_q | drop_start;
    assign wr_en        = in_valid & ~dropping;

    always_comb begin
        full_d = full_q;
        if (rd_free) begin
            full_d[rd_sel_q] = 1'b0;
        end
        if (wr_en && wr_last) begin
            full_d[wr_sel_q] = 1'b1;
        end
    end

    // Payload storage needs no reset: the full flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_q[wr_sel_q][wcnt_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            wr_sel_q   <= 1'b0;
            wcnt_q     <= '0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                max_q[b] <= '0;
            end
        end else begin
            full_q <= full_d;
            if (in_valid) begin
                // The word counter also runs through a dropped burst so the
                // next burst starts aligned.
                wcnt_q <= wcnt_q + IDX_W'(1);
                if (wr_last) begin
                    drop_q <= 1'b0;
                end else if (drop_start) begin
                    drop_q <= 1'b1;
                end
                if (wr_en && wr_last) begin
                    wr_sel_q <= ~wr_sel_q;
                end
            end
            if (drop_start) begin
                overflow_q <= 1'b1;
            end
            if (wr_en) begin
                if (wcnt_q == '0) begin
                    max_q[wr_sel_q] <= in_data;
                end else if (in_data > max_q[wr_sel_q]) begin
                    max_q[wr_sel_q] <= in_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign hs       = out_valid_q & out_ready;
    assign idx_last = (idx_q == IDX_W'(N_WORDS - 1));
    assign rd_free  = (state_q == DRAIN) & hs & idx_last;
    assign idx_nxt  = idx_q + IDX_W'(1);

    assign msb        = msb_index(max_q[rd_sel_q]);
    assign calc_shift = (msb > SHIFT_W'(OUT_W - 1)) ? (msb - SHIFT_W'(OUT_W - 1)) : '0;

    // CALC preloads byte 0 with the freshly computed shift; DRAIN prefetches
    // the byte after the one currently presented.
    assign rs_word  = bank_q[rd_sel_q][(state_q == CALC) ? '0 : idx_nxt];
    assign rs_shift = (state_q == CALC) ? calc_shift : shift_q;

    dcs_round_sat u_round_sat (
        .word_i  (rs_word),
        .shift_i (rs_shift),
        .byte_o  (rs_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_sel_q    <= 1'b0;
            idx_q       <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (full_q[rd_sel_q]) begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    shift_q     <= calc_shift;
                    idx_q       <= '0;
                    out_data_q  <= rs_byte;
                    out_last_q  <= (N_WORDS == 1);
                    out_valid_q <= 1'b1;
                    state_q     <= DRAIN;
                end
                DRAIN: begin
                    if (hs) begin
                        if (idx_last) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            rd_sel_q    <= ~rd_sel_q;
                            state_q     <= full_q[~rd_sel_q] ? CALC : IDLE;
                        end else begin
                            idx_q      <= idx_nxt;
                            out_data_q <= rs_byte;
                            out_last_q <= (idx_nxt == IDX_W'(N_WORDS - 1));
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_shift = shift_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dcs_out_requant.sv
// tb/tb_dcs_out_requant.sv - randomized self-checking bench for dcs_out_requant
module tb_dcs_out_requant;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [4:0]  out_shift;
    logic        out_last;
    logic        overflow;

    always #5 clk = ~clk;

    dcs_out_requant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] data;
        logic [4:0] shift;
        logic       last;
    } exp_t;

    exp_t        expq[$];
    int          pending = 0;   // complete bursts held, not yet fully drained
    int          m_wcnt = 0;
    bit          m_drop = 0;
    bit          m_ovf = 0;
    logic [31:0] m_words[8];
    bit          prev_stall = 0;
    logic [7:0]  prev_data;
    logic [4:0]  prev_shift;
    logic        prev_last;
    int          hs_count = 0;

    // Shift so that the burst maximum fits in 8 bits.
    function automatic int ref_shift(input logic [31:0] mx);
        int bits = 0;
        while ((longint'(1) << bits) <= longint'(mx)) bits++;
        return (bits > 8) ? bits - 8 : 0;
    endfunction

    // floor(w / 2^s + 1/2), clamped to 255.
    function automatic int ref_byte(input logic [31:0] w, input int s);
        longint p = longint'(1) << s;
        longint r = (2 * longint'(w) + p) / (2 * p);
        if (r > 255) r = 255;
        return int'(r);
    endfunction

    task automatic push_burst();
        logic [31:0] mx = '0;
        int s;
        exp_t e;
        foreach (m_words[i]) if (m_words[i] > mx) mx = m_words[i];
        s = ref_shift(mx);
        for (int i = 0; i < 8; i++) begin
            e.data  = 8'(ref_byte(m_words[i], s));
            e.shift = 5'(s);
            e.last  = (i == 7);
            expq.push_back(e);
        end
    endtask

    // Evaluates what the coming clock edge does, using the present outputs
    // and the inputs already applied for this cycle.
    task automatic step_model();
        exp_t e;
        check_eq("overflow", overflow, m_ovf);
        if (prev_stall) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, prev_data);
            check_eq("hold_shift", out_shift, prev_shift);
            check_eq("hold_last", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
            hs_count++;
            check_eq("byte_expected", 64'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check_eq("data", out_data, e.data);
                check_eq("shift", out_shift, e.shift);
                check_eq("last", out_last, e.last);
                if (e.last) pending--;
            end
        end
        if (in_valid) begin
            if (m_wcnt == 0) begin
                m_drop = (pending >= 2);
                if (m_drop) m_ovf = 1;
            end
            if (!m_drop) m_words[m_wcnt] = in_data;
            m_wcnt++;
            if (m_wcnt == 8) begin
                m_wcnt = 0;
                if (!m_drop) begin
                    push_burst();
                    pending++;
                end
                m_drop = 0;
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_shift = out_shift;
        prev_last  = out_last;
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        int n = 0;
        while ((expq.size() != 0 || out_valid) && n < 300) begin
            cycle(0, '0, 1);
            n++;
        end
        check_eq("flush_empty", expq.size(), 0);
        check_eq("flush_idle", out_valid, 0);
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_shift", out_shift, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_ovf", overflow, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        expq.delete();
        pending    = 0;
        m_wcnt     = 0;
        m_drop     = 0;
        m_ovf      = 0;
        prev_stall = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] t3[8];
    int pat[4];

    initial begin
        t3  = '{32'h0080_0000, 32'h8000_0000, 32'h007F_FFFF, 32'h0100_0000,
                32'h0000_0000, 32'h4000_0000, 32'h00FF_FFFF, 32'h7FFF_FFFF};
        pat = '{1, 0, 0, 1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("init_valid", out_valid, 0);
        check_eq("init_data", out_data, 0);
        check_eq("init_shift", out_shift, 0);
        check_eq("init_last", out_last, 0);
        check_eq("init_ovf", overflow, 0);
        rst_n = 1'b1;
        cycle(0, '0, 1);

        // burst 0..7, shift 0, latency of two edges after the 8th word
        for (int i = 0; i < 8; i++) cycle(1, 32'(i), 1);
        check_eq("lat_k", out_valid, 0);
        cycle(0, '0, 1);
        check_eq("lat_k1", out_valid, 0);
        cycle(0, '0, 1);
        check_eq("lat_k2", out_valid, 1);
        check_eq("lat_k2_data", out_data, 0);
        flush();

        // shift 2 with saturation of the rounded maximum
        for (int i = 0; i < 8; i++) cycle(1, (i == 7) ? 32'h3FF : 32'h300, 1);
        flush();

        // max 0x8000_0000 -> shift 24
        for (int i = 0; i < 8; i++) cycle(1, t3[i], 1);
        flush();

        // stalled drain with out_ready 1,0,0,1,...
        for (int i = 0; i < 8; i++) cycle(1, $urandom & 32'h000F_FFFF, 0);
        for (int i = 0; i < 40; i++) cycle(0, '0, pat[i % 4] != 0);
        flush();

        // three back-to-back bursts with no drain: the third is dropped
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 8; i++) cycle(1, 32'((b + 1) * 100 + i * 7), 0);
        cycle(0, '0, 0);
        check_eq("ovf_set", overflow, 1);
        hs_count = 0;
        flush();
        check_eq("drop_bytes", hs_count, 16);

        // reset during a stalled drain and after 4 words of the next burst
        for (int i = 0; i < 8; i++) cycle(1, 32'h1234 * (i + 1), 0);
        repeat (3) cycle(0, '0, 0);
        check_eq("pre_rst_valid", out_valid, 1);
        for (int i = 0; i < 4; i++) cycle(1, 32'hABCD_0000 + 32'(i), 0);
        mid_reset();
        cycle(0, '0, 1);
        check_eq("post_rst_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) cycle(1, 32'(i * 1000), 1);
        flush();

        // randomized bursts, gaps and backpressure
        for (int b = 0; b < 30; b++) begin
            int k = $urandom_range(0, 31);
            logic [31:0] mask = (k == 31) ? 32'hFFFF_FFFF : ((32'h1 << (k + 1)) - 1);
            for (int i = 0; i < 8; i++) begin
                while ($urandom_range(0, 3) == 0) cycle(0, '0, $urandom_range(0, 9) < 7);
                cycle(1, $urandom & mask, $urandom_range(0, 9) < 7);
            end
        end
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
